// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic light sequencer: state encodings,
// default tick timings and per-road lamp codes.
package traffic_pkg;

  typedef enum logic [2:0] {
    StLoGreen  = 3'd0,
    StLoYellow = 3'd1,
    StRedA     = 3'd2,
    StNsGreen  = 3'd3,
    StNsYellow = 3'd4,
    StRedB     = 3'd5,
    StFlash    = 3'd6
  } state_e;

  localparam int unsigned PhaseW = 3;

  localparam int unsigned DefMinGreen   = 4;
  localparam int unsigned DefMaxNsGreen = 8;
  localparam int unsigned DefYellowT    = 2;
  localparam int unsigned DefAllredT    = 1;

  // Per-road lamp codes ordered {red, yellow, green}.
  localparam logic [2:0] LampRed    = 3'b100;
  localparam logic [2:0] LampYellow = 3'b010;
  localparam logic [2:0] LampGreen  = 3'b001;

  // Lamp set for a steady state, packed as {main road, secondary road}.
  function automatic logic [5:0] road_lamps(state_e s);
    logic [5:0] l;
    l = {LampRed, LampRed};
    case (s)
      StLoGreen:  l = {LampGreen, LampRed};
      StLoYellow: l = {LampYellow, LampRed};
      StNsGreen:  l = {LampRed, LampGreen};
      StNsYellow: l = {LampRed, LampYellow};
      default:    l = {LampRed, LampRed};
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_light_sequencer_if.sv
// Request/lamp bundle between the traffic controller (master) and the lamp
// sequencer (slave). flash_req_i exists only when TLS_FLASH_EN is defined.
interface traffic_light_sequencer_if;
  import traffic_pkg::*;

  logic              tick_i;
  logic              req_lo_i;
  logic              req_ns_i;
`ifdef TLS_FLASH_EN
  logic              flash_req_i;
`endif
  logic              lo_red_o;
  logic              lo_yellow_o;
  logic              lo_green_o;
  logic              ns_red_o;
  logic              ns_yellow_o;
  logic              ns_green_o;
  logic [PhaseW-1:0] phase_o;

  modport master (
    output tick_i,
    output req_lo_i,
    output req_ns_i,
`ifdef TLS_FLASH_EN
    output flash_req_i,
`endif
    input  lo_red_o,
    input  lo_yellow_o,
    input  lo_green_o,
    input  ns_red_o,
    input  ns_yellow_o,
    input  ns_green_o,
    input  phase_o
  );

  modport slave (
    input  tick_i,
    input  req_lo_i,
    input  req_ns_i,
`ifdef TLS_FLASH_EN
    input  flash_req_i,
`endif
    output lo_red_o,
    output lo_yellow_o,
    output lo_green_o,
    output ns_red_o,
    output ns_yellow_o,
    output ns_green_o,
    output phase_o
  );

endinterface

// File: rtl/tick_timer.sv
// Saturating tick counter with synchronous clear and a "reached target-1" flag.
module tick_timer #(
  parameter int unsigned CntW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear_i,
  input  logic            tick_i,
  input  logic [CntW-1:0] target_i,
  output logic [CntW-1:0] cnt_o,
  output logic            last_o
);

  logic [CntW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (tick_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == (target_i - CntW'(1)));

endmodule

// File: rtl/traffic_light_sequencer.sv
// Lamp sequencer with min-green, yellow, all-red and max secondary-green timing
// counted in ticks. Define TLS_FLASH_EN to add the flash_req yellow-blink mode.
module traffic_light_sequencer
  import traffic_pkg::*;
#(
  parameter int unsigned MinGreen   = DefMinGreen,
  parameter int unsigned MaxNsGreen = DefMaxNsGreen,
  parameter int unsigned YellowT    = DefYellowT,
  parameter int unsigned AllredT    = DefAllredT
) (
  input logic                       clk,
  input logic                       rst_n,
  traffic_light_sequencer_if.slave  bus
);

  localparam int unsigned CntW = $clog2(MaxNsGreen + 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt;
  logic [CntW-1:0] target;
  logic            last;
  logic            min_met;
  logic            ns_only;
  logic            tick;
  logic [5:0]      lamps;

  assign tick    = bus.tick_i;
  // Only the clean "secondary wants it, main does not" code moves traffic to
  // the secondary road; both-set and both-clear favour the main road.
  assign ns_only = bus.req_ns_i & ~bus.req_lo_i;
  assign min_met = (cnt >= CntW'(MinGreen - 1));

  always_comb begin
    target = CntW'(MinGreen);
    case (state_q)
      StLoYellow, StNsYellow: target = CntW'(YellowT);
      StRedA, StRedB:         target = CntW'(AllredT);
      StNsGreen:              target = CntW'(MaxNsGreen);
      default:                target = CntW'(MinGreen);
    endcase
  end

  tick_timer #(
    .CntW (CntW)
  ) u_tick_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (state_d != state_q),
    .tick_i   (tick),
    .target_i (target),
    .cnt_o    (cnt),
    .last_o   (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StLoGreen;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLoGreen: begin
        if (tick && min_met && ns_only) state_d = StLoYellow;
      end
      StLoYellow: begin
        if (tick && last) state_d = StRedA;
      end
      StRedA: begin
        if (tick && last) state_d = StNsGreen;
      end
      StNsGreen: begin
        if (tick && (last || (min_met && !ns_only))) state_d = StNsYellow;
      end
      StNsYellow: begin
        if (tick && last) state_d = StRedB;
      end
      StRedB: begin
        if (tick && last) state_d = StLoGreen;
      end
`ifdef TLS_FLASH_EN
      StFlash: begin
        if (!bus.flash_req_i) state_d = StRedB;
      end
`endif
      // Unused codes fall back to the all-red clearance before main green.
      default: state_d = StRedB;
    endcase
`ifdef TLS_FLASH_EN
    if (bus.flash_req_i) state_d = StFlash;
`endif
  end

`ifdef TLS_FLASH_EN
  logic blink_d, blink_q;

  always_comb begin
    blink_d = blink_q;
    if (state_q != StFlash) begin
      blink_d = 1'b1;
    end else if (tick) begin
      blink_d = ~blink_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_q <= 1'b1;
    end else begin
      blink_q <= blink_d;
    end
  end
`endif

  always_comb begin
    lamps = road_lamps(state_q);
`ifdef TLS_FLASH_EN
    if (state_q == StFlash) begin
      lamps = {1'b0, blink_q, 1'b0, 1'b0, blink_q, 1'b0};
    end
`endif
  end

  assign bus.lo_red_o    = lamps[5];
  assign bus.lo_yellow_o = lamps[4];
  assign bus.lo_green_o  = lamps[3];
  assign bus.ns_red_o    = lamps[2];
  assign bus.ns_yellow_o = lamps[1];
  assign bus.ns_green_o  = lamps[0];
  assign bus.phase_o     = state_q;

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// Directed bench for traffic_light_sequencer: sequencing, timing limits,
// request decoding, tick gating, async reset and lamp safety on every cycle.
module tb_traffic_light_sequencer;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cmps  = 0;
  int   errs  = 0;

  traffic_light_sequencer_if bus ();

  traffic_light_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] obs_lamps();
    return {bus.lo_red_o, bus.lo_yellow_o, bus.lo_green_o,
            bus.ns_red_o, bus.ns_yellow_o, bus.ns_green_o};
  endfunction

  // Expected lamps for a phase, {lo r,y,g, ns r,y,g}.
  function automatic logic [5:0] exp_lamps(input int ph);
    case (ph)
      0:       return 6'b001_100;
      1:       return 6'b010_100;
      3:       return 6'b100_001;
      4:       return 6'b100_010;
      default: return 6'b100_100;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n && (bus.phase_o != 3'd6)) begin
      cmps++;
      if (((bus.lo_green_o | bus.lo_yellow_o) & (bus.ns_green_o | bus.ns_yellow_o)) ||
          !$onehot({bus.lo_red_o, bus.lo_yellow_o, bus.lo_green_o}) ||
          !$onehot({bus.ns_red_o, bus.ns_yellow_o, bus.ns_green_o})) begin
        $display("FAIL safety: lamps=%b phase=%0d at %0t", obs_lamps(), bus.phase_o, $time);
        errs++;
      end
    end
  end

  task automatic do_tick();
    @(negedge clk);
    bus.tick_i = 1'b1;
    @(negedge clk);
    bus.tick_i = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n      = 1'b0;
    bus.req_lo_i = 1'b0;
    bus.req_ns_i = 1'b0;
    bus.tick_i   = 1'b0;
`ifdef TLS_FLASH_EN
    bus.flash_req_i = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    cmps++;
    if ({bus.phase_o, obs_lamps()} !== {3'd0, 6'b001_100}) begin
      $display("FAIL reset_hold: got phase=%0d lamps=%b want 0/001100", bus.phase_o, obs_lamps());
      errs++;
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    cmps++;
    if ({bus.phase_o, obs_lamps()} !== {3'd0, 6'b001_100}) begin
      $display("FAIL reset_release: got phase=%0d lamps=%b want 0/001100", bus.phase_o, obs_lamps());
      errs++;
    end
  endtask

  task automatic test_lo_to_ns();
    int exp_ph[7] = '{0, 0, 0, 1, 1, 2, 3};
    apply_reset();
    bus.req_ns_i = 1'b1;
    for (int k = 0; k < 7; k++) begin
      do_tick();
      cmps++;
      if ({bus.phase_o, obs_lamps()} !== {3'(exp_ph[k]), exp_lamps(exp_ph[k])}) begin
        $display("FAIL lo_to_ns tick %0d: got phase=%0d lamps=%b want phase=%0d lamps=%b",
                 k + 1, bus.phase_o, obs_lamps(), exp_ph[k], exp_lamps(exp_ph[k]));
        errs++;
      end
    end
  endtask

  // Continues from NS_GREEN entered by test_lo_to_ns with req_ns still held.
  task automatic test_ns_max();
    int exp_ph[11] = '{3, 3, 3, 3, 3, 3, 3, 4, 4, 5, 0};
    for (int k = 0; k < 11; k++) begin
      do_tick();
      cmps++;
      if ({bus.phase_o, obs_lamps()} !== {3'(exp_ph[k]), exp_lamps(exp_ph[k])}) begin
        $display("FAIL ns_max tick %0d: got phase=%0d lamps=%b want phase=%0d lamps=%b",
                 k + 1, bus.phase_o, obs_lamps(), exp_ph[k], exp_lamps(exp_ph[k]));
        errs++;
      end
    end
  endtask

  task automatic test_ns_early_drop();
    int exp_ph[9] = '{3, 3, 3, 4, 4, 5, 0, 0, 0};
    apply_reset();
    bus.req_ns_i = 1'b1;
    repeat (7) do_tick();
    bus.req_ns_i = 1'b0;
    for (int k = 0; k < 9; k++) begin
      do_tick();
      cmps++;
      if ({bus.phase_o, obs_lamps()} !== {3'(exp_ph[k]), exp_lamps(exp_ph[k])}) begin
        $display("FAIL ns_early tick %0d: got phase=%0d lamps=%b want phase=%0d lamps=%b",
                 k + 1, bus.phase_o, obs_lamps(), exp_ph[k], exp_lamps(exp_ph[k]));
        errs++;
      end
    end
  endtask

  task automatic test_both_and_glitch();
    apply_reset();
    bus.req_lo_i = 1'b1;
    bus.req_ns_i = 1'b1;
    for (int k = 0; k < 20; k++) begin
      do_tick();
      cmps++;
      if (bus.phase_o !== 3'd0) begin
        $display("FAIL both_req tick %0d: got phase=%0d want 0", k + 1, bus.phase_o);
        errs++;
      end
    end
    bus.req_lo_i = 1'b0;
    bus.req_ns_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.req_ns_i = 1'b1;
      @(negedge clk);
      bus.req_ns_i = 1'b0;
    end
    cmps++;
    if (bus.phase_o !== 3'd0) begin
      $display("FAIL glitch_no_tick: got phase=%0d want 0", bus.phase_o);
      errs++;
    end
    do_tick();
    cmps++;
    if (bus.phase_o !== 3'd0) begin
      $display("FAIL glitch_idle_tick: got phase=%0d want 0", bus.phase_o);
      errs++;
    end
    // Green has long exceeded its minimum, so the first valid request leaves at once.
    bus.req_ns_i = 1'b1;
    do_tick();
    cmps++;
    if ({bus.phase_o, obs_lamps()} !== {3'd1, 6'b010_100}) begin
      $display("FAIL late_req: got phase=%0d lamps=%b want 1/010100", bus.phase_o, obs_lamps());
      errs++;
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    bus.req_ns_i = 1'b1;
    repeat (7) do_tick();
    bus.req_ns_i = 1'b0;
    repeat (4) do_tick();
    cmps++;
    if (bus.phase_o !== 3'd4) begin
      $display("FAIL pre_reset: got phase=%0d want 4", bus.phase_o);
      errs++;
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    cmps++;
    if ({bus.phase_o, obs_lamps()} !== {3'd0, 6'b001_100}) begin
      $display("FAIL async_reset: got phase=%0d lamps=%b want 0/001100", bus.phase_o, obs_lamps());
      errs++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_tick();
    cmps++;
    if (bus.phase_o !== 3'd0) begin
      $display("FAIL post_reset: got phase=%0d want 0", bus.phase_o);
      errs++;
    end
  endtask

`ifdef TLS_FLASH_EN
  task automatic test_flash();
    apply_reset();
    bus.req_ns_i = 1'b1;
    repeat (7) do_tick();
    bus.flash_req_i = 1'b1;
    @(negedge clk);
    cmps++;
    if ({bus.phase_o, obs_lamps()} !== {3'd6, 6'b010_010}) begin
      $display("FAIL flash_entry: got phase=%0d lamps=%b want 6/010010", bus.phase_o, obs_lamps());
      errs++;
    end
    do_tick();
    cmps++;
    if ({bus.phase_o, obs_lamps()} !== {3'd6, 6'b000_000}) begin
      $display("FAIL flash_blink0: got phase=%0d lamps=%b want 6/000000", bus.phase_o, obs_lamps());
      errs++;
    end
    do_tick();
    cmps++;
    if ({bus.phase_o, obs_lamps()} !== {3'd6, 6'b010_010}) begin
      $display("FAIL flash_blink1: got phase=%0d lamps=%b want 6/010010", bus.phase_o, obs_lamps());
      errs++;
    end
    bus.flash_req_i = 1'b0;
    bus.req_ns_i    = 1'b0;
    @(negedge clk);
    cmps++;
    if ({bus.phase_o, obs_lamps()} !== {3'd5, 6'b100_100}) begin
      $display("FAIL flash_exit: got phase=%0d lamps=%b want 5/100100", bus.phase_o, obs_lamps());
      errs++;
    end
    do_tick();
    cmps++;
    if ({bus.phase_o, obs_lamps()} !== {3'd0, 6'b001_100}) begin
      $display("FAIL flash_to_lo: got phase=%0d lamps=%b want 0/001100", bus.phase_o, obs_lamps());
      errs++;
    end
  endtask
`endif

  initial begin
    bus.tick_i   = 1'b0;
    bus.req_lo_i = 1'b0;
    bus.req_ns_i = 1'b0;
`ifdef TLS_FLASH_EN
    bus.flash_req_i = 1'b0;
`endif
    test_reset();
    test_lo_to_ns();
    test_ns_max();
    test_ns_early_drop();
    test_both_and_glitch();
    test_async_reset();
`ifdef TLS_FLASH_EN
    test_flash();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

endmodule
